// File: rtl/spi_point_tx.sv
// SPI master that serialises one {x,y} display point per 32-bit word, MSB first,
// and captures the word returned on sdi. sclk idles low; data is set up on the low phase.
module spi_point_tx #(
  parameter int CLK_DIV   = 4,
  parameter int WORD_BITS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [9:0]           xpt,
  input  logic [9:0]           ypt,
  input  logic                 sdi,
  output logic                 sclk,
  output logic                 sdo,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_BITS-1:0] rx_data
);

  localparam int         CNT_W    = $clog2(WORD_BITS);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t               state, state_n;
  logic [WORD_BITS-1:0] shreg, shreg_n;
  logic [WORD_BITS-1:0] rx_sh, rx_sh_n;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_n;
  logic [7:0]           div_cnt, div_cnt_n;

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    rx_sh_n   = rx_sh;
    bit_cnt_n = bit_cnt;
    div_cnt_n = div_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          shreg_n   = WORD_BITS'({6'b0, xpt, 6'b0, ypt});
          bit_cnt_n = CNT_W'(WORD_BITS - 1);
          div_cnt_n = 8'd0;
          state_n   = LOW;
        end
      end
      LOW: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_n = 8'd0;
          state_n   = HIGH;
        end else begin
          div_cnt_n = div_cnt + 8'd1;
        end
      end
      HIGH: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_n = 8'd0;
          // sdi is taken at the very end of the high phase, i.e. just before the fall
          rx_sh_n   = {rx_sh[WORD_BITS-2:0], sdi};
          if (bit_cnt == '0) begin
            state_n = DONE;
          end else begin
            shreg_n   = {shreg[WORD_BITS-2:0], 1'b0};
            bit_cnt_n = bit_cnt - CNT_W'(1);
            state_n   = LOW;
          end
        end else begin
          div_cnt_n = div_cnt + 8'd1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      rx_sh   <= '0;
      bit_cnt <= '0;
      div_cnt <= 8'd0;
      sclk    <= 1'b0;
      sdo     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      rx_sh   <= rx_sh_n;
      bit_cnt <= bit_cnt_n;
      div_cnt <= div_cnt_n;
      sclk    <= (state_n == HIGH);
      // shreg only moves on HIGH->LOW, so sdo cannot change while sclk is high
      sdo     <= (state_n == LOW || state_n == HIGH) ? shreg_n[WORD_BITS-1] : 1'b0;
      busy    <= (state_n != IDLE);
      done    <= (state_n == DONE);
      if (state_n == DONE) rx_data <= rx_sh_n;
    end
  end

endmodule

// File: tb/tb_spi_point_tx.sv
// Directed bench for spi_point_tx with a loopback slave and a point-receiver model on the link.
module tb_spi_point_tx;

  localparam int CD = 2;

  logic        clk = 1'b0;
  logic        reset, start, sdi;
  logic [9:0]  xpt, ypt;
  logic        sclk, sdo, busy, done;
  logic [31:0] rx_data;

  spi_point_tx #(.CLK_DIV(CD), .WORD_BITS(32)) dut (
    .clk(clk), .reset(reset), .start(start), .xpt(xpt), .ypt(ypt), .sdi(sdi),
    .sclk(sclk), .sdo(sdo), .busy(busy), .done(done), .rx_data(rx_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Link monitor, loopback slave and point-receiver model, all sampled mid-cycle.
  logic        sclk_q = 1'b0, sdo_q = 1'b0, busy_q = 1'b0;
  int          rises = 0, done_cnt = 0, done_cyc = 0, nrise = 0;
  int          rise_a = 0, rise_b = 0, busy_last = 0, hi_chg = 0;
  logic [31:0] cap = '0, rx_at_done = '0;
  logic [31:0] slv_word = '0;
  int          slv_idx = 0;
  logic [31:0] rsh = '0;
  logic [4:0]  rcnt = '0;
  logic [9:0]  rx_x = '0, rx_y = '0;

  always @(negedge clk) begin
    if (sclk && !sclk_q) begin
      rises++;
      cap = {cap[30:0], sdo};
    end
    if (sclk && sclk_q && (sdo != sdo_q)) hi_chg++;
    if (done) begin
      done_cnt++;
      done_cyc   = cyc;
      rx_at_done = rx_data;
    end
    if (busy) busy_last = cyc;
    if (busy && !busy_q) begin
      nrise++;
      rise_a = rise_b;
      rise_b = cyc;
    end
    if (!busy) begin
      slv_idx = 0;
      sdi     = slv_word[31];
    end else if (!sclk && sclk_q && slv_idx < 31) begin
      slv_idx++;
      sdi = slv_word[31 - slv_idx];
    end
    if (reset) begin
      rcnt = '0;
    end else if (sclk && !sclk_q) begin
      rsh = {rsh[30:0], sdo};
      if (rcnt == 5'd31) begin
        rx_x = rsh[25:16];
        rx_y = rsh[9:0];
      end
      rcnt = rcnt + 5'd1;
    end
    sclk_q = sclk;
    sdo_q  = sdo;
    busy_q = busy;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [9:0] x, input logic [9:0] y, output int n);
    @(posedge clk);
    #1;
    xpt   = x;
    ypt   = y;
    start = 1'b1;
    n     = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    xpt   = ~x;
    ypt   = ~y;
  endtask

  task automatic wait_done(input int d0, input int want, input string tag);
    for (int i = 0; i < 600 && done_cnt < d0 + want; i++) tick();
    chk(tag, 32'(done_cnt >= d0 + want), 32'd1);
  endtask

  int n, r0, d0, nr0, hc0;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    xpt   = '0;
    ypt   = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tick();
    chk("rst_sclk", 32'(sclk), 0);
    chk("rst_sdo", 32'(sdo), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rx", rx_data, 0);

    // single transfer with loopback
    slv_word = 32'hDEAD_BEEF;
    r0 = rises; d0 = done_cnt; hc0 = hi_chg;
    send(10'h155, 10'h2AA, n);
    wait_done(d0, 1, "t1_tmo");
    repeat (5) tick();
    chk("t1_rises", 32'(rises - r0), 32);
    chk("t1_word", cap, 32'h0155_02AA);
    chk("t1_done_cyc", 32'(done_cyc - n), 129);
    chk("t1_done_cnt", 32'(done_cnt - d0), 1);
    chk("t1_busy_first", 32'(rise_b - n), 1);
    chk("t1_busy_last", 32'(busy_last - n), 129);
    chk("t1_sdo_stable", 32'(hi_chg - hc0), 0);
    chk("lb_rx_done", rx_at_done, 32'hDEAD_BEEF);
    chk("lb_rx_hold", rx_data, 32'hDEAD_BEEF);
    chk("t1_rcv_x", 32'(rx_x), 32'h155);
    chk("t1_rcv_y", 32'(rx_y), 32'h2AA);

    // end-to-end points through the receiver model
    d0 = done_cnt;
    send(10'd639, 10'd479, n);
    wait_done(d0, 1, "e2e1_tmo");
    tick();
    chk("e2e1_x", 32'(rx_x), 32'h27F);
    chk("e2e1_y", 32'(rx_y), 32'h1DF);
    d0 = done_cnt;
    send(10'd0, 10'd1023, n);
    wait_done(d0, 1, "e2e2_tmo");
    tick();
    chk("e2e2_x", 32'(rx_x), 32'h000);
    chk("e2e2_y", 32'(rx_y), 32'h3FF);

    // start while busy is ignored
    r0 = rises; d0 = done_cnt; nr0 = nrise;
    send(10'h0AB, 10'h0CD, n);
    while (cyc < n + 10) begin
      @(posedge clk);
      #1;
    end
    xpt = 10'h3F0; ypt = 10'h00F; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (300) tick();
    chk("sb_word", cap, 32'h00AB_00CD);
    chk("sb_rises", 32'(rises - r0), 32);
    chk("sb_dones", 32'(done_cnt - d0), 1);
    chk("sb_accepts", 32'(nrise - nr0), 1);

    // start held high: back-to-back accepts
    d0 = done_cnt; nr0 = nrise;
    @(posedge clk);
    #1;
    xpt = 10'h201; ypt = 10'h102; start = 1'b1;
    n = cyc;
    for (int i = 0; i < 400 && nrise < nr0 + 2; i++) tick();
    chk("hold_two_accepts", 32'(nrise - nr0), 2);
    chk("hold_first", 32'(rise_a - n), 1);
    chk("hold_spacing", 32'(rise_b - rise_a), 130);
    start = 1'b0;
    wait_done(d0, 2, "hold_tmo");
    chk("hold_word", cap, 32'h0201_0102);

    // reset in the middle of a transfer
    repeat (3) tick();
    r0 = rises;
    send(10'h3FF, 10'h3FF, n);
    for (int i = 0; i < 200 && rises < r0 + 12; i++) tick();
    chk("mr_reach_bit12", 32'(rises - r0), 12);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    chk("mr_sclk", 32'(sclk), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_done", 32'(done), 0);
    chk("mr_rx", rx_data, 0);
    slv_word = 32'h1234_5678;
    r0 = rises; d0 = done_cnt;
    send(10'h1E5, 10'h05A, n);
    wait_done(d0, 1, "mr2_tmo");
    tick();
    chk("mr2_rises", 32'(rises - r0), 32);
    chk("mr2_word", cap, 32'h01E5_005A);
    chk("mr2_rx", rx_data, 32'h1234_5678);
    chk("mr2_rcv_x", 32'(rx_x), 32'h1E5);
    chk("mr2_rcv_y", 32'(rx_y), 32'h05A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_point_tx.md
Name: spi_point_tx

Overview:
- SPI master that serialises one display point per transfer to the FPGA point receiver.
- Each transfer is one 32-bit word: {6'b0, xpt[9:0], 6'b0, ypt[9:0]}, sent MSB first on sdo.
- The block generates sclk, which is low when idle.
- It also captures the 32 bits returned on sdi and presents them on rx_data.
- It sits on the MCU/test side of the link and drives the receiver's sclk/sdo inputs.

Parameters:
- CLK_DIV, default 4: clk cycles per sclk half-period (sclk period = 2*CLK_DIV clk cycles); legal range 1..255.
- WORD_BITS, default 32: bits per transfer; fixed at 32 for the point format.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request a transfer; sampled only in IDLE
- xpt  in  10  x coordinate, latched at accept
- ypt  in  10  y coordinate, latched at accept
- sdi  in  1  serial data returned from the receiver
- sclk  out  1  SPI clock, registered, idle low
- sdo  out  1  serial data to the receiver, registered
- busy  out  1  high from the cycle after accept through the DONE cycle
- done  out  1  one-cycle pulse, transfer complete
- rx_data  out  32  word captured from sdi, MSB first

Behaviour:
- Reset, synchronous, takes priority over everything:
  - state=IDLE; sclk=0, sdo=0, busy=0, done=0, rx_data=0.
  - Shift register, bit counter and divider all 0.
- States: IDLE, LOW, HIGH, DONE.
- IDLE:
  - sclk=0, sdo=0, busy=0.
  - If start=1 in cycle N:
    - latch shreg={6'b0,xpt,6'b0,ypt};
    - bit_cnt=31, div_cnt=0;
    - go LOW in N+1, with sdo=shreg[31].
- LOW (sclk=0, busy=1):
  - Hold for CLK_DIV cycles, then go HIGH.
  - sdo is stable for the whole LOW phase.
- HIGH (sclk=1, busy=1):
  - Hold for CLK_DIV cycles.
  - In the last HIGH cycle, shift sdi into the LSB of the rx shift register.
  - Then:
    - if bit_cnt==0, go DONE;
    - else shift shreg left by 1, bit_cnt-=1, go LOW with sdo=new shreg[31].
- DONE (sclk=0, sdo=0, busy=1, done=1 for exactly one cycle):
  - rx_data takes the full 32-bit rx shift value.
  - Go IDLE next cycle.
- Timing for start accepted in cycle N:
  - first sclk rise is visible at N+1+CLK_DIV;
  - the 32nd sclk fall is at N+1+64*CLK_DIV;
  - done is high at N+1+64*CLK_DIV.
- Exactly 32 rising sclk edges per transfer, never more or fewer.
  - This keeps the receiver's free-running 5-bit bit counter word-aligned.
- sdo changes only in the cycle sclk goes low (or on LOW entry). It is never changed while sclk=1, so the receiver's rising-edge sampling sees stable data.
- start is ignored in LOW/HIGH/DONE; it is not queued.
  - If start is held high continuously, the next accept occurs in the IDLE cycle after DONE.
  - Minimum spacing between accepts is therefore 64*CLK_DIV+2 cycles.
- xpt/ypt changes after accept do not affect the transfer in flight.
- Only bits [9:0] of each coordinate are transmitted; bits 31:26 and 15:10 are always 0.
- Reset mid-transfer: the next cycle is IDLE with sclk=0 and busy=0, and rx_data is cleared.
  - The partial word is lost.
  - The system must reset the receiver with the same reset so its bit counter realigns.
- div_cnt width is 8 bits; the comparison is div_cnt==CLK_DIV-1.
- CLK_DIV=1 is legal: sclk toggles every clk cycle.

Test Plan:
- Single transfer:
  - Stimulus: CLK_DIV=2, xpt=10'h155, ypt=10'h2AA, start pulse in cycle N.
  - Required: sdo samples on the 32 rising sclk edges = 32'h0155_02AA MSB first; exactly 32 rises; done high only in cycle N+129; busy high N+1..N+129.
- Loopback:
  - Stimulus: bench slave model drives sdi on falling sclk with 32'hDEAD_BEEF (MSB first).
  - Required: rx_data==32'hDEADBEEF in the done cycle; rx_data holds that value afterwards.
- End-to-end with the point receiver:
  - Stimulus: send (x=639,y=479), then (x=0,y=1023), with both blocks sharing reset.
  - Required: receiver xpt/ypt read 639/479, then 0/1023 (x=10'h27F, y=10'h1DF, then 0/10'h3FF).
- Start while busy:
  - Stimulus: pulse start at N+10 during a transfer with different x/y.
  - Required: no effect on the in-flight word; no second transfer occurs.
- Start held high:
  - Stimulus: hold start=1 from N.
  - Required: second accept occurs exactly at N+130 (CLK_DIV=2).
- Reset mid-operation:
  - Stimulus: assert reset for one cycle at bit 12 of a transfer.
  - Required: next cycle sclk=0, busy=0, done=0, rx_data=0; a subsequent transfer completes correctly with 32 rises.
